// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and defaults for the loadable instruction memory
package instr_mem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - synchronous-write, synchronous-read storage array
module instr_mem_array #(
  parameter int IDX_W = 8,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register; the top masks them until a fetch selects memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - loadable instruction memory with LOAD/RUN control
// Optional parity storage and checking under INSTR_MEM_PARITY_EN.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                DATA_W       = DATA_W_DEF,
  parameter int                DEPTH        = DEPTH_DEF,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              addr_err
`ifdef INSTR_MEM_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t           state;
  logic             mem_sel;
  logic             accept;
  logic             in_range;
  logic             beyond_depth;
  logic             rd_en;
  logic             last_slot;
  logic [MEM_W-1:0] wdata;
  logic [MEM_W-1:0] rdata;

  assign load_ready   = (state == ST_LOAD);
  assign busy         = (state == ST_LOAD);
  assign accept       = load_ready & load_valid;
  assign in_range     = {1'b0, address} < words_loaded;
  assign beyond_depth = {1'b0, address} >= DEPTH_L;
  assign rd_en        = (state == ST_RUN) & fetch_en & in_range;
  assign last_slot    = (words_loaded == DEPTH_L - 1'b1);

`ifdef INSTR_MEM_PARITY_EN
  assign wdata      = {^load_data, load_data};
  assign parity_err = data_valid & mem_sel & ((^rdata[DATA_W-1:0]) != rdata[DATA_W]);
`else
  assign wdata      = load_data;
`endif

  instr_mem_array #(
    .IDX_W (IDX_W),
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (words_loaded[IDX_W-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (address[IDX_W-1:0]),
    .rdata (rdata)
  );

  // mem_sel remembers whether the last fetch hit a loaded word; otherwise the default is shown.
  assign data = mem_sel ? rdata[DATA_W-1:0] : DEFAULT_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_LOAD;
      words_loaded <= '0;
      data_valid   <= 1'b0;
      addr_err     <= 1'b0;
      mem_sel      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      addr_err   <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            words_loaded <= words_loaded + 1'b1;
            if (load_last || last_slot) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_en) begin
            data_valid <= 1'b1;
            addr_err   <= beyond_depth;
            mem_sel    <= in_range;
          end
          if (reload) begin
            state        <= ST_LOAD;
            words_loaded <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
